// File: rtl/axi_bram_bank_rw.sv
// AXI4-Lite slave giving word access to BRAM_COUNT BRAM banks over one shared port-A bus.
// Optional write path enabled by defining AXI_BRAM_BANK_WRITE_EN.
module axi_bram_bank_rw #(
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_ADDR_WIDTH  = 16,
    parameter int unsigned BRAM_DATA_WIDTH = 32,
    parameter int unsigned BRAM_ADDR_WIDTH = 10,
    parameter int unsigned BRAM_COUNT      = 2,
    parameter int unsigned READ_LATENCY    = 1
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]                 s_axi_awaddr,
    input  logic                                      s_axi_awvalid,
    output logic                                      s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]                 s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]               s_axi_wstrb,
    input  logic                                      s_axi_wvalid,
    output logic                                      s_axi_wready,
    output logic [1:0]                                s_axi_bresp,
    output logic                                      s_axi_bvalid,
    input  logic                                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]                 s_axi_araddr,
    input  logic                                      s_axi_arvalid,
    output logic                                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]                 s_axi_rdata,
    output logic [1:0]                                s_axi_rresp,
    output logic                                      s_axi_rvalid,
    input  logic                                      s_axi_rready,
    output logic                                      bram_porta_clk,
    output logic                                      bram_porta_rst,
    output logic [BRAM_COUNT-1:0]                     bram_porta_en,
    output logic [BRAM_COUNT*BRAM_DATA_WIDTH/8-1:0]   bram_porta_we,
    output logic [BRAM_ADDR_WIDTH-1:0]                bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]                bram_porta_wrdata,
    input  logic [BRAM_COUNT*BRAM_DATA_WIDTH-1:0]     bram_porta_rddata
);

    localparam int unsigned STRB_WIDTH = BRAM_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned SEL_WIDTH  = (BRAM_COUNT > 1) ? $clog2(BRAM_COUNT) : 1;
    localparam int unsigned SEL_LSB    = ADDR_LSB + BRAM_ADDR_WIDTH;
    localparam logic [SEL_WIDTH:0] BANK_LIMIT = BRAM_COUNT[SEL_WIDTH:0];
    localparam logic [2:0]         LAT        = READ_LATENCY[2:0];

`ifdef AXI_BRAM_BANK_WRITE_EN
    typedef enum logic [2:0] {StIdle, StRdWait, StRdResp, StWrExec, StWrResp} state_e;
`else
    typedef enum logic [2:0] {StIdle, StRdWait, StRdResp} state_e;
`endif

    state_e                       state_q, state_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic [BRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SEL_WIDTH-1:0]         bank_q, bank_d;
    logic                         decerr_q, decerr_d;
    logic [BRAM_COUNT-1:0]        en_q, en_d;
    logic [AXI_DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [1:0]                   rresp_q, rresp_d;
    logic [BRAM_DATA_WIDTH-1:0]   rd_sel;

    logic [BRAM_ADDR_WIDTH-1:0]   ar_word;
    logic [SEL_WIDTH-1:0]         ar_bank;
    logic                         ar_decerr;

    assign ar_word   = s_axi_araddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
    assign ar_bank   = s_axi_araddr[SEL_LSB +: SEL_WIDTH];
    assign ar_decerr = {1'b0, ar_bank} >= BANK_LIMIT;

    function automatic logic [BRAM_COUNT-1:0] bank_onehot(input logic [SEL_WIDTH-1:0] bank);
        logic [BRAM_COUNT-1:0] oh;
        oh = '0;
        for (int k = 0; k < BRAM_COUNT; k++) begin
            if (bank == SEL_WIDTH'(k)) oh[k] = 1'b1;
        end
        return oh;
    endfunction

    // Bank mux; out-of-range banks never reach capture, decode error forces zero instead.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < BRAM_COUNT; k++) begin
            if (bank_q == SEL_WIDTH'(k)) begin
                rd_sel = bram_porta_rddata[k*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
            end
        end
    end

`ifdef AXI_BRAM_BANK_WRITE_EN
    logic [BRAM_ADDR_WIDTH-1:0]           aw_word;
    logic [SEL_WIDTH-1:0]                 aw_bank;
    logic                                 aw_decerr;
    logic                                 aw_hs;
    logic [BRAM_DATA_WIDTH-1:0]           wrdata_q, wrdata_d;
    logic [BRAM_COUNT*STRB_WIDTH-1:0]     we_q, we_d;
    logic [1:0]                           bresp_q, bresp_d;

    assign aw_word   = s_axi_awaddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
    assign aw_bank   = s_axi_awaddr[SEL_LSB +: SEL_WIDTH];
    assign aw_decerr = {1'b0, aw_bank} >= BANK_LIMIT;
    // AW and W are taken together, and only when no read competes for the slot.
    assign aw_hs = aresetn && (state_q == StIdle) && s_axi_awvalid && s_axi_wvalid &&
                   !s_axi_arvalid;

    function automatic logic [BRAM_COUNT*STRB_WIDTH-1:0] bank_strobes(
        input logic [SEL_WIDTH-1:0]  bank,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [BRAM_COUNT*STRB_WIDTH-1:0] s;
        s = '0;
        for (int k = 0; k < BRAM_COUNT; k++) begin
            if (bank == SEL_WIDTH'(k)) s[k*STRB_WIDTH +: STRB_WIDTH] = strb;
        end
        return s;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        decerr_d = decerr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        en_d     = '0;
`ifdef AXI_BRAM_BANK_WRITE_EN
        wrdata_d = wrdata_q;
        we_d     = '0;
        bresp_d  = bresp_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (s_axi_arvalid) begin
                    addr_d   = ar_word;
                    bank_d   = ar_bank;
                    decerr_d = ar_decerr;
                    cnt_d    = '0;
                    en_d     = ar_decerr ? '0 : bank_onehot(ar_bank);
                    state_d  = StRdWait;
                end
`ifdef AXI_BRAM_BANK_WRITE_EN
                else if (aw_hs) begin
                    addr_d   = aw_word;
                    bank_d   = aw_bank;
                    decerr_d = aw_decerr;
                    wrdata_d = s_axi_wdata;
                    if (!aw_decerr) begin
                        en_d = bank_onehot(aw_bank);
                        we_d = bank_strobes(aw_bank, s_axi_wstrb);
                    end
                    state_d = StWrExec;
                end
`endif
            end
            StRdWait: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAT) begin
                    rdata_d = decerr_q ? '0 : rd_sel;
                    rresp_d = decerr_q ? 2'b11 : 2'b00;
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                if (s_axi_rready) state_d = StIdle;
            end
`ifdef AXI_BRAM_BANK_WRITE_EN
            StWrExec: begin
                bresp_d = decerr_q ? 2'b11 : 2'b00;
                state_d = StWrResp;
            end
            StWrResp: begin
                if (s_axi_bready) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            bank_q   <= '0;
            decerr_q <= 1'b0;
            en_q     <= '0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            decerr_q <= decerr_d;
            en_q     <= en_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_en   = en_q;
    assign bram_porta_addr = addr_q;
    assign s_axi_arready   = aresetn && (state_q == StIdle);
    assign s_axi_rvalid    = (state_q == StRdResp);
    assign s_axi_rdata     = rdata_q;
    assign s_axi_rresp     = rresp_q;

    logic unused_bits;

`ifdef AXI_BRAM_BANK_WRITE_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wrdata_q <= '0;
            we_q     <= '0;
            bresp_q  <= 2'b00;
        end else begin
            wrdata_q <= wrdata_d;
            we_q     <= we_d;
            bresp_q  <= bresp_d;
        end
    end

    assign s_axi_awready     = aw_hs;
    assign s_axi_wready      = aw_hs;
    assign s_axi_bvalid      = (state_q == StWrResp);
    assign s_axi_bresp       = bresp_q;
    assign bram_porta_we     = we_q;
    assign bram_porta_wrdata = wrdata_q;
    assign unused_bits       = ^{s_axi_araddr, s_axi_awaddr};
`else
    assign s_axi_awready     = 1'b0;
    assign s_axi_wready      = 1'b0;
    assign s_axi_bvalid      = 1'b0;
    assign s_axi_bresp       = 2'b00;
    assign bram_porta_we     = '0;
    assign bram_porta_wrdata = '0;
    assign unused_bits       = ^{s_axi_araddr, s_axi_awaddr, s_axi_awvalid, s_axi_wdata,
                                 s_axi_wstrb, s_axi_wvalid, s_axi_bready};
`endif

endmodule
